// File: rtl/jt89_bus_pkg.sv
// Shared constants and types for the jt89 CPU write front-end.
// Optional feature macro: JT89_BUS_STEREO_EN (Game Gear stereo register).
package jt89_pkg;

  // Channel field of the latch byte, din[6:5]
  localparam logic [1:0] CH_T0    = 2'd0;
  localparam logic [1:0] CH_T1    = 2'd1;
  localparam logic [1:0] CH_T2    = 2'd2;
  localparam logic [1:0] CH_NOISE = 2'd3;

  // Type field of the latch byte, din[4]
  localparam logic TYP_TONE = 1'b0;
  localparam logic TYP_VOL  = 1'b1;

  // Reset values
  localparam logic [3:0] VOL_RST    = 4'hF;
  localparam logic [7:0] STEREO_RST = 8'hFF;

  // Write-wait FSM
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } fsm_state_t;

  // Register currently addressed by data bytes
  typedef struct packed {
    logic [1:0] ch;
    logic       typ;
  } latch_t;

endpackage

// File: rtl/jt89_bus_if.sv
// CPU-side bus of the PSG: write strobe, data byte, stereo strobe, READY.
// Handshake: a write is taken on the clk where wr_n is seen falling
// (previous sample high, current low) while ready=1; ready then stays low
// for the wait period, and edges arriving while ready=0 are discarded.
interface jt89_bus_if;
  logic       wr_n;
  logic [7:0] din;
  logic       st_we;
  logic       ready;

  modport master (output wr_n, din, st_we, input ready);
  modport slave  (input wr_n, din, st_we, output ready);
endinterface

// File: rtl/jt89_bus_wait.sv
// Write-edge detect plus the IDLE/BUSY READY timer for the PSG bus.
// accept is a single-clk qualifier of a new write; ready is registered.
module jt89_bus_wait
  import jt89_pkg::*;
#(
  parameter int unsigned WAIT_CYC = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic       wr_n,
  output logic       accept,
  output logic       ready,
  output fsm_state_t state
);

  localparam logic [7:0] WCNT_LAST = 8'(WAIT_CYC - 1);

  logic       wr_l_q;
  fsm_state_t state_q;
  logic [7:0] wcnt_q;
  logic       ready_q;

  // Previous wr_n sample; a held-low strobe produces only one edge
  always_ff @(posedge clk) begin
    if (rst) wr_l_q <= 1'b1;
    else     wr_l_q <= wr_n;
  end

  // Falling edge seen while idle is a write; edges during BUSY are lost
  assign accept = wr_l_q & ~wr_n & (state_q == ST_IDLE);

  // READY timer: counts WAIT_CYC cen ticks spent in BUSY
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      wcnt_q  <= 8'd0;
      ready_q <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_q <= ST_BUSY;
            wcnt_q  <= 8'd0;
            ready_q <= 1'b0;
          end
        end
        ST_BUSY: begin
          if (cen) begin
            if (wcnt_q == WCNT_LAST) begin
              state_q <= ST_IDLE;
              ready_q <= 1'b1;
            end else begin
              wcnt_q <= wcnt_q + 8'd1;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign ready = ready_q;
  assign state = state_q;

endmodule

// File: rtl/jt89_bus.sv
// SN76489-compatible PSG CPU write front-end: latch/data byte decode into
// the tone/volume/noise register file and the READY wait handshake.
// Optional feature macro: JT89_BUS_STEREO_EN enables the stereo register.
module jt89_bus
  import jt89_pkg::*;
#(
  parameter int unsigned WAIT_CYC = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cen,
  jt89_bus_if.slave   bus,
  output logic [9:0]  tone0,
  output logic [9:0]  tone1,
  output logic [9:0]  tone2,
  output logic [3:0]  vol0,
  output logic [3:0]  vol1,
  output logic [3:0]  vol2,
  output logic [3:0]  vol3,
  output logic [2:0]  ctrl3,
  output logic        clr,
  output logic [7:0]  stereo,
  output fsm_state_t  state_dbg
);

  logic       accept;
  logic       ready_w;

  latch_t     latch_q;
  latch_t     sel;
  logic [9:0] tone0_q, tone1_q, tone2_q;
  logic [3:0] vol0_q, vol1_q, vol2_q, vol3_q;
  logic [2:0] ctrl3_q;
  logic       clr_q;

  jt89_bus_wait #(.WAIT_CYC(WAIT_CYC)) u_wait (
    .clk    (clk),
    .rst    (rst),
    .cen    (cen),
    .wr_n   (bus.wr_n),
    .accept (accept),
    .ready  (ready_w),
    .state  (state_dbg)
  );

  assign bus.ready = ready_w;

  // Target register: a latch byte addresses itself, a data byte uses the latch
  always_comb begin
    sel = latch_q;
    if (bus.din[7]) sel = {bus.din[6:5], bus.din[4]};
  end

  // Register file update on an accepted write; clr is a one-clk pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      latch_q <= {CH_T0, TYP_TONE};
      tone0_q <= 10'd0;
      tone1_q <= 10'd0;
      tone2_q <= 10'd0;
      vol0_q  <= VOL_RST;
      vol1_q  <= VOL_RST;
      vol2_q  <= VOL_RST;
      vol3_q  <= VOL_RST;
      ctrl3_q <= 3'd0;
      clr_q   <= 1'b0;
    end else begin
      clr_q <= 1'b0;
      if (accept) begin
        if (bus.din[7]) latch_q <= sel;
        if (sel.typ == TYP_VOL) begin
          case (sel.ch)
            CH_T0:   vol0_q <= bus.din[3:0];
            CH_T1:   vol1_q <= bus.din[3:0];
            CH_T2:   vol2_q <= bus.din[3:0];
            default: vol3_q <= bus.din[3:0];
          endcase
        end else if (sel.ch == CH_NOISE) begin
          ctrl3_q <= bus.din[2:0];
          clr_q   <= 1'b1;
        end else if (bus.din[7]) begin
          // Latch byte carries the low nibble of the period
          case (sel.ch)
            CH_T0:   tone0_q[3:0] <= bus.din[3:0];
            CH_T1:   tone1_q[3:0] <= bus.din[3:0];
            default: tone2_q[3:0] <= bus.din[3:0];
          endcase
        end else begin
          // Data byte carries the upper six bits of the period
          case (sel.ch)
            CH_T0:   tone0_q[9:4] <= bus.din[5:0];
            CH_T1:   tone1_q[9:4] <= bus.din[5:0];
            default: tone2_q[9:4] <= bus.din[5:0];
          endcase
        end
      end
    end
  end

`ifdef JT89_BUS_STEREO_EN
  logic [7:0] stereo_q;

  // Stereo mask written directly, regardless of the READY state
  always_ff @(posedge clk) begin
    if (rst)             stereo_q <= STEREO_RST;
    else if (bus.st_we)  stereo_q <= bus.din;
  end

  assign stereo = stereo_q;
`else
  logic unused_st_we;
  assign unused_st_we = bus.st_we;
  assign stereo       = STEREO_RST;
`endif

  assign tone0 = tone0_q;
  assign tone1 = tone1_q;
  assign tone2 = tone2_q;
  assign vol0  = vol0_q;
  assign vol1  = vol1_q;
  assign vol2  = vol2_q;
  assign vol3  = vol3_q;
  assign ctrl3 = ctrl3_q;
  assign clr   = clr_q;

endmodule

// File: tb/tb_jt89_bus.sv
// Bench for jt89_bus: directed writes with hand-computed register values,
// a monitor that checks registers on each READY fall, READY low length in
// cen ticks, clr pulse width, and explicit probes at quiet points.
module tb_jt89_bus;
  import jt89_pkg::*;

  typedef struct packed {
    logic [9:0] t0;
    logic [9:0] t1;
    logic [9:0] t2;
    logic [3:0] v0;
    logic [3:0] v1;
    logic [3:0] v2;
    logic [3:0] v3;
    logic [2:0] c3;
    logic [7:0] st;
    logic       rdy;
  } snap_t;

  localparam int SW = $bits(snap_t);

  // ---------------- clock / reset / cen ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cen = 1'b0;
  logic       cen_en = 1'b1;
  logic [1:0] div = 2'd0;

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cen_en) begin
      cen = (div == 2'd3);
      div = div + 2'd1;
    end else begin
      cen = 1'b0;
    end
  end

  // ---------------- DUT ----------------
  jt89_bus_if bus();
  logic [9:0] tone0, tone1, tone2;
  logic [3:0] vol0, vol1, vol2, vol3;
  logic [2:0] ctrl3;
  logic       clr;
  logic [7:0] stereo;
  fsm_state_t state_dbg;

  jt89_bus #(.WAIT_CYC(32)) dut (
    .clk(clk), .rst(rst), .cen(cen), .bus(bus),
    .tone0(tone0), .tone1(tone1), .tone2(tone2),
    .vol0(vol0), .vol1(vol1), .vol2(vol2), .vol3(vol3),
    .ctrl3(ctrl3), .clr(clr), .stereo(stereo), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [SW-1:0] exp_q[$];   // register snapshot expected at each READY fall
  logic [SW-1:0] prb_q[$];   // snapshots for explicit probes
  logic [7:0]    len_q[$];   // expected cen ticks of low READY per write
  logic [7:0]    clrw_q[$];  // expected clr pulse width per noise write
  int   probe_cnt = 0;
  int   probe_seen = 0;
  logic in_rst = 1'b1;
  logic prev_rdy = 1'b1;
  logic measuring = 1'b0;
  int   busy_cens = 0;
  int   clr_w = 0;
  snap_t exp_s;

  task automatic cmp(input string nm, input logic [15:0] act, input logic [15:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, expv, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    errors++;
    $display("FAIL %s t=%0t", nm, $time);
  endtask

  task automatic check_snap(input string tag, input snap_t e);
    cmp({tag, ".tone0"},  16'(tone0),     16'(e.t0));
    cmp({tag, ".tone1"},  16'(tone1),     16'(e.t1));
    cmp({tag, ".tone2"},  16'(tone2),     16'(e.t2));
    cmp({tag, ".vol0"},   16'(vol0),      16'(e.v0));
    cmp({tag, ".vol1"},   16'(vol1),      16'(e.v1));
    cmp({tag, ".vol2"},   16'(vol2),      16'(e.v2));
    cmp({tag, ".vol3"},   16'(vol3),      16'(e.v3));
    cmp({tag, ".ctrl3"},  16'(ctrl3),     16'(e.c3));
    cmp({tag, ".stereo"}, 16'(stereo),    16'(e.st));
    cmp({tag, ".ready"},  16'(bus.ready), 16'(e.rdy));
  endtask

  // Monitor: samples 1 time unit after each rising edge
  always @(posedge clk) begin
    #1;
    if (in_rst) begin
      measuring = 1'b0;
      clr_w     = 0;
    end else begin
      if (prev_rdy === 1'b1 && bus.ready === 1'b0) begin
        if (exp_q.size() == 0) fail_now("spurious_write");
        else check_snap("write", snap_t'(exp_q.pop_front()));
        busy_cens = 0;
        measuring = 1'b1;
      end else if (prev_rdy === 1'b0) begin
        if (cen) busy_cens++;
        if (bus.ready === 1'b1 && measuring) begin
          measuring = 1'b0;
          if (len_q.size() == 0) fail_now("busy_unexpected");
          else cmp("busy_cens", 16'(busy_cens), 16'(len_q.pop_front()));
        end
      end
      if (clr === 1'b1) begin
        clr_w++;
      end else if (clr_w > 0) begin
        if (clrw_q.size() == 0) fail_now("clr_unexpected");
        else cmp("clr_width", 16'(clr_w), 16'(clrw_q.pop_front()));
        clr_w = 0;
      end
    end
    if (probe_cnt != probe_seen) begin
      probe_seen++;
      check_snap("probe", snap_t'(prb_q.pop_front()));
    end
    prev_rdy = bus.ready;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int n = 0;
    while (bus.ready !== 1'b1 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (bus.ready !== 1'b1) fail_now("idle_timeout");
  endtask

  task automatic probe(input logic rdy);
    snap_t s;
    s = exp_s;
    s.rdy = rdy;
    prb_q.push_back(SW'(s));
    probe_cnt++;
    @(posedge clk); #2;
  endtask

  // Drives wr_n low with din; leaves wr_n low for the caller to release
  task automatic write_start(input logic [7:0] b, input logic noise);
    snap_t s;
    wait_idle();
    @(negedge clk);
    bus.wr_n = 1'b0;
    bus.din  = b;
    s = exp_s;
    s.rdy = 1'b0;
    exp_q.push_back(SW'(s));
    len_q.push_back(8'd32);
    if (noise) clrw_q.push_back(8'd1);
    @(negedge clk);
  endtask

  task automatic wr(input logic [7:0] b, input logic noise);
    write_start(b, noise);
    bus.wr_n = 1'b1;
    wait_idle();
  endtask

  task automatic set_reset_model();
    exp_s = '0;
    exp_s.v0 = 4'hF; exp_s.v1 = 4'hF; exp_s.v2 = 4'hF; exp_s.v3 = 4'hF;
    exp_s.st = 8'hFF;
    exp_s.rdy = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    in_rst = 1'b0;
    if (len_q.size() > 0) void'(len_q.pop_front());
    set_reset_model();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.wr_n = 1'b1;
    bus.din = 8'h00;
    bus.st_we = 1'b0;
    set_reset_model();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    in_rst = 1'b0;
    probe(1'b1);

    // tone0 low nibble then high six bits
    exp_s.t0 = 10'h00E; wr(8'h8E, 1'b0);
    exp_s.t0 = 10'h0FE; wr(8'h0F, 1'b0);

    // latch follows the last latch byte: data byte goes to vol2
    exp_s.t2 = 10'h003; wr(8'hC3, 1'b0);
    exp_s.v2 = 4'h5;    wr(8'hD5, 1'b0);
    exp_s.v2 = 4'h3;    wr(8'h03, 1'b0);

    // noise control via latch and data byte, each with one clr pulse
    exp_s.c3 = 3'd5; wr(8'hE5, 1'b1);
    exp_s.c3 = 3'd6; wr(8'h06, 1'b1);

    // wr_n held low across the end of BUSY: no second write
    exp_s.v1 = 4'h7;
    write_start(8'hB7, 1'b0);
    wait_idle();
    repeat (5) @(negedge clk);
    bus.wr_n = 1'b1;
    probe(1'b1);

    // second falling edge during BUSY is dropped
    exp_s.v0 = 4'hA;
    write_start(8'h9A, 1'b0);
    bus.wr_n = 1'b1;
    repeat (10) @(negedge clk);
    bus.wr_n = 1'b0;
    bus.din  = 8'h9F;
    repeat (3) @(negedge clk);
    bus.wr_n = 1'b1;
    wait_idle();
    probe(1'b1);

    // stereo strobe while BUSY
    exp_s.t1 = 10'h005;
    write_start(8'hA5, 1'b0);
    bus.wr_n = 1'b1;
    repeat (5) @(negedge clk);
    bus.st_we = 1'b1;
    bus.din   = 8'h5A;
    @(negedge clk);
    bus.st_we = 1'b0;
`ifdef JT89_BUS_STEREO_EN
    exp_s.st = 8'h5A;
`endif
    wait_idle();
    probe(1'b1);

    // cen held low keeps BUSY; count resumes afterwards
    exp_s.v1 = 4'h4;
    write_start(8'hB4, 1'b0);
    bus.wr_n = 1'b1;
    @(negedge clk);
    cen_en = 1'b0;
    repeat (200) @(negedge clk);
    probe(1'b0);
    @(negedge clk);
    cen_en = 1'b1;
    wait_idle();
    probe(1'b1);

    // reset in the middle of BUSY
    exp_s.t0 = 10'h0FF;
    write_start(8'h8F, 1'b0);
    bus.wr_n = 1'b1;
    repeat (20) @(negedge clk);
    do_reset();
    probe(1'b1);

    // latch back at channel 0 tone after reset
    exp_s.t0 = 10'h120; wr(8'h12, 1'b0);

    repeat (4) @(negedge clk);
    cmp("exp_q_left",  16'(exp_q.size()),  16'd0);
    cmp("len_q_left",  16'(len_q.size()),  16'd0);
    cmp("clrw_q_left", 16'(clrw_q.size()), 16'd0);
    cmp("prb_q_left",  16'(prb_q.size()),  16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound
  initial begin
    #400000;
    $display("FAIL global_timeout t=%0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/jt89_bus.md
Name: jt89_bus

Overview:
- CPU-side write front-end of the SN76489-compatible PSG.
- Decodes the latch/data byte protocol into the register file that feeds the tone channels, the noise channel and the volume stages: tone0..2, vol0..3, ctrl3 and the clr pulse.
- Drives the chip READY handshake: READY stays low for a fixed number of chip clock-enable ticks after each accepted write.

Parameters:
- WAIT_CYC, 32: cen ticks READY stays low after an accepted write; legal range 1..255.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- cen  in  1  chip clock enable (undivided chip clock, before the /16 used by channels)
- wr_n  in  1  CPU write strobe, active-low, level
- din  in  8  CPU data byte, valid while wr_n low
- ready  out  1  1 = idle and able to accept a write
- tone0, tone1, tone2  out  10 each  tone period registers
- vol0, vol1, vol2, vol3  out  4 each  attenuation registers (F = silent)
- ctrl3  out  3  noise control: [2] white/periodic, [1:0] rate
- clr  out  1  one-clk pulse on any noise-control write (resets the noise LFSR)
- stereo  out  8  Game Gear stereo mask (see Optional Feature)
- st_we  in  1  stereo register write strobe, active-high (see Optional Feature)

Behaviour:
- Reset values:
  - tone0..2 = 0; vol0..3 = 4'hF; ctrl3 = 0; clr = 0; ready = 1; stereo = 8'hFF.
  - Latch = channel 0, type tone.
  - wr_n history register = 1.
- Write detection:
  - wr_l = wr_n sampled each clk.
  - Accept when wr_l=1, wr_n=0 and FSM is IDLE.
  - Decode and register update happen on that same clk edge; new values are visible the next cycle.
  - A held-low wr_n is one write only.
- Latch byte (din[7]=1):
  - latch <= {din[6:5] channel, din[4] type}.
  - Type 1 (volume): volN <= din[3:0].
  - Type 0, channel 0..2 (tone): toneN[3:0] <= din[3:0]; toneN[9:4] unchanged.
  - Type 0, channel 3 (noise): ctrl3 <= din[2:0]; din[3] ignored; clr = 1 for exactly one clk.
- Data byte (din[7]=0): applies to the current latch; the latch itself is unchanged.
  - Tone: toneN[9:4] <= din[5:0]; din[6] ignored.
  - Volume: volN <= din[3:0].
  - Noise: ctrl3 <= din[2:0]; clr pulse as above.
- FSM, two states:
  - IDLE: ready=1. An accepted write sets wcnt <= 0 and moves to BUSY; ready=0 from the next cycle.
  - BUSY: ready=0. wcnt (8-bit) increments on each cen.
  - On the cen where wcnt == WAIT_CYC-1, return to IDLE; ready=1 the next cycle.
  - Exactly WAIT_CYC cen ticks of low ready.
- Boundary conditions:
  - A falling wr_n edge while BUSY is dropped: no register change, no clr, BUSY timing unaffected.
  - The edge is not re-armed until wr_n returns high and falls again while IDLE.
  - Reset in BUSY: IDLE with ready=1 and all registers at reset values the cycle after rst.
  - If cen is held low the FSM stays BUSY indefinitely.

Optional Feature:
- Macro: JT89_BUS_STEREO_EN
- Defined:
  - stereo <= din when st_we=1, on that clk edge, independent of FSM state and ready.
  - A simultaneous PSG write is still processed normally.
- Undefined:
  - stereo tied to 8'hFF.
  - st_we ignored; the port remains for a stable interface.

Decomposition:
- jt89_pkg:
  - Channel codes CH_T0..CH_T2, CH_NOISE.
  - Type codes TYP_TONE, TYP_VOL.
  - Reset constants VOL_RST=4'hF, STEREO_RST=8'hFF.
  - FSM state enum {ST_IDLE, ST_BUSY}.
- One sub-module is natural: jt89_bus_wait, holding the edge detect, the IDLE/BUSY FSM and the wcnt counter; outputs accept and ready.
- The register file stays in jt89_bus.

Test Plan:
- Reset: ready=1, tone0..2=000, vol0..3=F, ctrl3=0, clr=0, stereo=FF.
- Write 8E then 0F (each after ready returns) -> tone0=0FE. Ready low for exactly 32 cen after each write; with cen every 4th clk, 128 clk.
- Write C3, D5, then 03 -> tone2[3:0]=3, vol2=5, then vol2=3; latch follows the last latch byte, so the data byte goes to vol2, not tone2.
- Write E5 -> ctrl3=5 and clr high exactly one clk; then 06 -> ctrl3=6 with a second one-clk clr; tone3 does not exist, vol3 unchanged.
- Write 9A, then a second wr_n falling edge with din=9F during BUSY -> vol0=A, no change from the second byte, ready rises at cen 32 from the first write; rst asserted mid-BUSY -> ready=1 and all outputs at reset values next cycle.
- With JT89_BUS_STEREO_EN: st_we with din=5A while BUSY -> stereo=5A next cycle. Without it -> stereo stays FF.
